iterative_sqrt_param: RTL and testbench
=======================================

# iterative_sqrt_param

Parametrised integer square-root engine: accepts an unsigned WIDTH-bit operand on a valid/ready input channel and returns floor(sqrt(n)) plus remainder n − root² on a valid/ready output channel. It computes by binary search, one iteration per cycle, with one shared multiplier. It supersedes the fixed 8-bit, exact-only square-root proc. It adds width parametrisation, correct results for non-square operands, a remainder output, optional early exit, and overlap of a new computation with a stalled result.

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 2
- EARLY_EXIT, 1, 1 = terminate the search as soon as mid² == n; 0 = fixed-latency search
- ROOT_W (localparam), (WIDTH+1)/2, root width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- in_data  in  WIDTH  operand n
- in_vld  in  1  operand valid
- in_rdy  out  1  operand accepted on an edge where in_vld & in_rdy
- out_root  out  ROOT_W  floor(sqrt(n)), registered
- out_rem  out  ROOT_W+1  n − out_root², registered
- out_vld  out  1  result valid, registered
- out_rdy  in  1  consumer ready; result retires on an edge where out_vld & out_rdy

## Operation
- Registers: n (WIDTH), lo and hi (ROOT_W), state ∈ {IDLE, SEARCH, EMIT}, output register (root, rem, vld).
- in_rdy = (state == IDLE) & ~rst. Accept: latch n, lo = 0, hi = 2^ROOT_W − 1, go to SEARCH.
- SEARCH, lo ≠ hi:
  - mid = (lo + hi + 1) >> 1, computed at ROOT_W+1 bits with no overflow.
  - sq = mid·mid at 2·ROOT_W bits, compared against zero-extended n.
  - sq ≤ n: lo = mid. Otherwise: hi = mid − 1.
  - EARLY_EXIT=1 and sq == n: lo = hi = mid.
- SEARCH, lo == hi: the result is root = lo, rem = n − lo² truncated to ROOT_W+1 bits.
  - If the output register is free (~out_vld | out_rdy), load it and go to IDLE.
  - Otherwise go to EMIT.
- EMIT: hold root and rem. Load the output register and go to IDLE on the first edge where ~out_vld | out_rdy.
- Output register: out_vld is set on load. It clears on retire unless a new load occurs on the same edge; a load wins on that edge. Data registers change only on load.
- Overlap: a new operand may be accepted in IDLE while an earlier result is still waiting in the output register.
- Range sizes are always powers of two, so fixed mode takes exactly ROOT_W iterations. Remainder is always ≤ 2·root and always fits in ROOT_W+1 bits.
- Reset: state = IDLE, out_vld = 0, out_root = 0, out_rem = 0, lo = hi = n = 0. Reset asserted during SEARCH or EMIT discards the operation in flight and any pending result. in_rdy = 0 while rst is high.

## Timing
- Latency runs from the accept edge to the edge that sets out_vld, with no backpressure.
  - EARLY_EXIT=0: ROOT_W + 1 cycles.
  - EARLY_EXIT=1: k + 1 cycles, where k is the iteration index (1-based) of the exact match. If no exact match occurs, the latency equals the fixed-mode value.
- Throughput: one result per ROOT_W + 2 cycles in fixed mode (accept, ROOT_W iterations, finalise, then back in IDLE).
- in_rdy is low for every cycle the state is not IDLE. in_rdy depends only on state and rst, with no combinational path from in_vld or out_rdy.
- out_root, out_rem and out_vld come straight from flops. They are stable while out_vld & ~out_rdy.
- Simultaneous retire and load on one edge: out_vld stays 1 and the data updates.

## Test plan
- WIDTH=16, EARLY_EXIT=0, n=144, out_rdy=1 -> root=12, rem=0, out_vld 9 cycles after accept; in_rdy high again the following cycle.
- WIDTH=16, EARLY_EXIT=1, n=144 -> root=12, rem=0, latency 7 (exact match at iteration 6, mid=12); n=200 -> root=14, rem=4, latency 9.
- Boundaries, WIDTH=16 -> n=0 gives root=0, rem=0; n=65535 gives root=255, rem=510; n=1 gives root=1, rem=0. WIDTH=5, n=31 -> root=5, rem=6.
- Backpressure -> hold out_rdy=0, send n=49 then n=50 back-to-back. First result (7, 0) is held stable. Second operand is accepted, and the engine sits in EMIT with in_rdy=0. Release out_rdy -> (7, 0) retires, (7, 1) loads on the same edge, out_vld stays 1.
- Reset mid-search -> assert rst for 1 cycle at iteration 3 of n=1000 -> out_vld=0, in_rdy=1 the cycle after rst drops, no stale result. The next operand, n=1000, returns root=31, rem=39.
- Random stress -> 10k random operands with random in_vld/out_rdy, both EARLY_EXIT settings, WIDTH ∈ {2, 7, 16, 32}. Every result must satisfy root² ≤ n < (root+1)², and results must appear in order with no drops or duplicates.

Source files
------------

// File: rtl/iterative_sqrt_param.sv
// iterative_sqrt_param: floor(sqrt(n)) and remainder n - root^2 by binary search
// over the root. One probe per cycle through a single squarer. Valid/ready on both
// sides. A new operand may be taken while an earlier result is still stalled at
// the output.
//
// state  | meaning
// IDLE   | waiting for an operand; the only state that accepts one
// SEARCH | narrowing [lo, hi]; finalises on the cycle lo == hi
// EMIT   | result known but output register still occupied; holds lo and n
module iterative_sqrt_param #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_vld,
  output logic                       in_rdy,
  output logic [(WIDTH+1)/2-1:0]     out_root,
  output logic [(WIDTH+1)/2:0]       out_rem,
  output logic                       out_vld,
  input  logic                       out_rdy
);
  localparam int ROOT_W = (WIDTH + 1) / 2;

  typedef enum logic [1:0] {IDLE, SEARCH, EMIT} state_t;

  state_t              state;
  logic [WIDTH-1:0]    n_q;
  logic [ROOT_W-1:0]   lo;
  logic [ROOT_W-1:0]   hi;
  logic [ROOT_W-1:0]   mid;
  logic [2*ROOT_W-1:0] sq;
  logic [2*ROOT_W-1:0] n_ext;
  logic [ROOT_W:0]     rem_now;
  logic                out_free;

  // Handshake depends only on state and reset, never on in_vld or out_rdy.
  assign in_rdy = (state == IDLE) && !rst;

  // Upper midpoint probe. Once lo == hi, mid equals lo, so the same squarer
  // also provides lo^2 for the remainder.
  always_comb begin
    mid      = ROOT_W'(({1'b0, lo} + {1'b0, hi} + (ROOT_W+1)'(1)) >> 1);
    sq       = {{ROOT_W{1'b0}}, mid} * {{ROOT_W{1'b0}}, mid};
    n_ext    = (2*ROOT_W)'(n_q);
    rem_now  = (ROOT_W+1)'(n_ext - sq);
    out_free = !out_vld || out_rdy;
  end

  // Sequencer, search range and output register. A load on the same edge as a
  // retire overrides the clear, so out_vld stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n_q      <= '0;
      lo       <= '0;
      hi       <= '0;
      out_vld  <= 1'b0;
      out_root <= '0;
      out_rem  <= '0;
    end else begin
      if (out_vld && out_rdy) out_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (in_vld) begin
            n_q   <= in_data;
            lo    <= '0;
            hi    <= '1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (lo != hi) begin
            if (EARLY_EXIT && (sq == n_ext)) begin
              lo <= mid;
              hi <= mid;
            end else if (sq <= n_ext) begin
              lo <= mid;
            end else begin
              hi <= mid - ROOT_W'(1);
            end
          end else if (out_free) begin
            out_root <= lo;
            out_rem  <= rem_now;
            out_vld  <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= EMIT;
          end
        end
        EMIT: begin
          if (out_free) begin
            out_root <= lo;
            out_rem  <= rem_now;
            out_vld  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_sqrt_param.sv
// Bench for iterative_sqrt_param: six instances of different width and mode,
// directed vectors with literal expectations, then random valid/ready traffic
// checked against an arithmetic square-root model and an in-order queue.
`timescale 1ns/1ps
module tb_iterative_sqrt_param;
  localparam int NI = 6;

  function automatic int w_of(int g);
    case (g)
      0, 1:    return 16;
      2:       return 5;
      3:       return 7;
      4:       return 32;
      default: return 2;
    endcase
  endfunction

  function automatic bit e_of(int g);
    return (g == 1) || (g == 3) || (g == 5);
  endfunction

  function automatic longint msk(int g);
    return (64'sd1 <<< w_of(g)) - 1;
  endfunction

  function automatic longint isqrt(longint n);
    longint r;
    r = longint'($rtoi($sqrt(real'(n))));
    while (r * r > n) r--;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data [NI];
  logic        in_vld  [NI];
  logic        out_rdy [NI];
  logic        in_rdy  [NI];
  logic        out_vld [NI];
  logic [31:0] root_a  [NI];
  logic [31:0] rem_a   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W  = w_of(g);
    localparam int RW = (W + 1) / 2;
    logic [RW-1:0] root;
    logic [RW:0]   rem;
    iterative_sqrt_param #(.WIDTH(W), .EARLY_EXIT(e_of(g))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data[g][W-1:0]),
      .in_vld   (in_vld[g]),
      .in_rdy   (in_rdy[g]),
      .out_root (root),
      .out_rem  (rem),
      .out_vld  (out_vld[g]),
      .out_rdy  (out_rdy[g])
    );
    assign root_a[g] = 32'(root);
    assign rem_a[g]  = 32'(rem);
  end

  typedef struct {
    longint n;
    int     acc;
    int     lat;
    longint lroot;
    longint lrem;
  } exp_t;

  // compare-process state
  exp_t        q [NI][$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          seen_seq = 0;
  int          vld_since [NI];
  bit          p_hold [NI];
  bit          p_vld  [NI];
  bit          p_ret  [NI];
  logic [31:0] p_root [NI];
  logic [31:0] p_rem  [NI];

  // driver-owned requests and literal expectations
  int     req_seq = 0;
  int     req_kind, req_g;
  longint req_a, req_b, req_c;
  int     lit_lat  [NI];
  longint lit_root [NI];
  longint lit_rem  [NI];

  task automatic chk(string name, int g, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d, want %0d", name, g, act, exp);
    end
  endtask

  task automatic do_req();
    case (req_kind)
      1: begin
        chk("in_rdy", req_g, longint'(in_rdy[req_g]), req_a);
        chk("out_vld", req_g, longint'(out_vld[req_g]), req_b);
      end
      2: begin
        chk("held_root", req_g, longint'(root_a[req_g]), req_a);
        chk("held_rem", req_g, longint'(rem_a[req_g]), req_b);
        chk("held_vld", req_g, longint'(out_vld[req_g]), req_c);
      end
      3: begin
        chk("drain_queue", req_g, longint'(q[req_g].size()), 0);
        chk("drain_vld", req_g, longint'(out_vld[req_g]), 0);
      end
      default: begin
        n_tests++;
        n_fail++;
        $display("FAIL wait_bound inst%0d: waited %0d cycles, limit %0d", req_g, req_a, req_b);
      end
    endcase
  endtask

  // Single compare process: accepts feed the model queue, retires are checked
  // against it, stalled outputs must hold, one-shot requests are served.
  always @(negedge clk) begin
    cyc++;
    if (req_seq != seen_seq) begin
      seen_seq = req_seq;
      do_req();
    end
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        q[g].delete();
        p_hold[g] = 1'b0;
        p_vld[g]  = 1'b0;
        p_ret[g]  = 1'b0;
      end else begin
        if (p_hold[g]) begin
          chk("stall_vld", g, longint'(out_vld[g]), 1);
          chk("stall_root", g, longint'(root_a[g]), longint'(p_root[g]));
          chk("stall_rem", g, longint'(rem_a[g]), longint'(p_rem[g]));
        end
        if (out_vld[g] && (!p_vld[g] || p_ret[g])) vld_since[g] = cyc;
        if (in_vld[g] && in_rdy[g]) begin
          exp_t e;
          e.n     = longint'(in_data[g]) & msk(g);
          e.acc   = cyc;
          e.lat   = lit_lat[g];
          e.lroot = lit_root[g];
          e.lrem  = lit_rem[g];
          q[g].push_back(e);
        end
        if (out_vld[g] && out_rdy[g]) begin
          if (q[g].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_result inst%0d: got root %0d rem %0d, want no result", g, root_a[g], rem_a[g]);
          end else begin
            exp_t   e;
            longint r;
            e = q[g].pop_front();
            r = isqrt(e.n);
            chk("model_root", g, longint'(root_a[g]), r);
            chk("model_rem", g, longint'(rem_a[g]), e.n - r * r);
            if (e.lroot >= 0) begin
              chk("lit_root", g, longint'(root_a[g]), e.lroot);
              chk("lit_rem", g, longint'(rem_a[g]), e.lrem);
            end
            if (e.lat >= 0) chk("latency", g, longint'(vld_since[g] - 1 - e.acc), longint'(e.lat));
          end
        end
        p_hold[g] = out_vld[g] && !out_rdy[g];
        p_vld[g]  = out_vld[g];
        p_ret[g]  = out_vld[g] && out_rdy[g];
        p_root[g] = root_a[g];
        p_rem[g]  = rem_a[g];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic post(int kind, int g, longint a, longint b, longint c);
    req_kind = kind;
    req_g    = g;
    req_a    = a;
    req_b    = b;
    req_c    = c;
    req_seq++;
    step();
  endtask

  task automatic send(int g, longint n, longint lr, longint lm, int lat);
    int t;
    t = 0;
    lit_root[g] = lr;
    lit_rem[g]  = lm;
    lit_lat[g]  = lat;
    in_data[g]  = 32'(n & msk(g));
    in_vld[g]   = 1'b1;
    while (!in_rdy[g] && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) post(4, g, t, 200, 0);
    step();
    in_vld[g]   = 1'b0;
    lit_root[g] = -1;
    lit_rem[g]  = -1;
    lit_lat[g]  = -1;
  endtask

  task automatic wait_vld(int g);
    int t;
    t = 0;
    while (!out_vld[g] && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) post(4, g, t, 100, 0);
  endtask

  task automatic drain(int g);
    int t;
    t = 0;
    while ((q[g].size() != 0 || out_vld[g]) && t < 300) begin
      step();
      t++;
    end
    if (t >= 300) post(4, g, t, 300, 0);
  endtask

  function automatic longint rand_op(int g);
    longint r;
    longint v;
    r = longint'($urandom_range(0, (1 << ((w_of(g) + 1) / 2)) - 1));
    case ($urandom_range(3))
      0:       v = r * r;
      1:       v = r * r - 1;
      default: v = longint'($urandom);
    endcase
    return v & msk(g);
  endfunction

  task automatic stress(int g, int nops);
    int sent;
    int t;
    bit acc;
    sent = 0;
    t    = 0;
    while ((sent < nops || q[g].size() != 0 || out_vld[g]) && t < 30000) begin
      acc = in_vld[g] && in_rdy[g];
      step();
      t++;
      if (acc) begin
        in_vld[g] = 1'b0;
        sent++;
      end
      out_rdy[g] = ($urandom_range(3) != 0);
      if (!in_vld[g] && sent < nops && $urandom_range(2) != 0) begin
        in_data[g] = 32'(rand_op(g));
        in_vld[g]  = 1'b1;
      end
    end
    if (t >= 30000) post(4, g, t, 30000, 0);
    in_vld[g]  = 1'b0;
    out_rdy[g] = 1'b1;
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < NI; g++) begin
      in_data[g]  = '0;
      in_vld[g]   = 1'b0;
      out_rdy[g]  = 1'b1;
      lit_root[g] = -1;
      lit_rem[g]  = -1;
      lit_lat[g]  = -1;
    end
    rst = 1'b1;
    step(); step(); step();
    post(1, 0, 0, 0, 0);
    rst = 1'b0;
    for (int g = 0; g < NI; g++) post(1, g, 1, 0, 0);
    post(2, 4, 0, 0, 0);

    // fixed-latency and early-exit basics
    send(0, 144, 12, 0, 9);
    post(1, 0, 0, 0, 0);
    wait_vld(0);
    post(1, 0, 1, 1, 0);
    drain(0);
    send(1, 144, 12, 0, 7);
    drain(1);
    send(1, 200, 14, 4, 9);
    drain(1);

    // boundaries
    send(0, 0, 0, 0, 9);
    send(0, 65535, 255, 510, 9);
    send(0, 1, 1, 0, 9);
    drain(0);
    send(1, 0, 0, 0, 9);
    drain(1);
    send(2, 31, 5, 6, 4);
    drain(2);
    send(5, 3, 1, 2, 2);
    send(5, 1, 1, 0, 2);
    drain(5);
    send(4, 64'hFFFF_FFFF, 65535, 131070, 17);
    drain(4);

    // backpressure with an operand overlapping a stalled result
    out_rdy[0] = 1'b0;
    send(0, 49, 7, 0, -1);
    send(0, 50, 7, 1, -1);
    for (int i = 0; i < 10; i++) step();
    post(1, 0, 0, 1, 0);
    post(2, 0, 7, 0, 1);
    out_rdy[0] = 1'b1;
    step();
    post(2, 0, 7, 1, 1);
    drain(0);

    // reset during the third iteration
    send(0, 1000, -1, -1, -1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    post(1, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) step();
    send(0, 1000, 31, 39, 9);
    drain(0);

    // random traffic on every instance
    for (int g = 0; g < NI; g++) stress(g, 500);

    for (int g = 0; g < NI; g++) post(3, g, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
